// File: rtl/div_16_by_8.sv
// Sequential radix-2 restoring divider: 16-bit dividend / 8-bit divisor, one quotient bit
// per clock, with a start/busy/done handshake and a single-cycle divide-by-zero path.
module div_16_by_8 #(
    parameter int unsigned N_W = 16,
    parameter int unsigned D_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [N_W-1:0] dividend_i,
    input  logic [D_W-1:0] divisor_i,
    output logic           busy_o,
    output logic           done_o,
    output logic           dbz_o,
    output logic [N_W-1:0] quotient_o,
    output logic [D_W-1:0] remainder_o
);

    localparam int unsigned CntW = $clog2(N_W);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e         state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [D_W:0]   p_q, p_d;         // partial remainder
    logic [N_W-1:0] q_q, q_d;         // dividend shifting out, quotient shifting in
    logic [D_W-1:0] div_q, div_d;     // latched divisor
    logic [N_W-1:0] quotient_q, quotient_d;
    logic [D_W-1:0] remainder_q, remainder_d;
    logic           done_q, done_d;
    logic           dbz_q, dbz_d;

    logic [D_W:0]   t_trial;
    logic [D_W:0]   p_step;
    logic [N_W-1:0] q_step;
    logic           last_iter;

    // After each restoring step P < divisor, so its top bit is always zero and never read.
    logic unused_p_msb;
    assign unused_p_msb = p_q[D_W];

    // One restoring iteration: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        t_trial = {p_q[D_W-1:0], q_q[N_W-1]};
        if (t_trial >= {1'b0, div_q}) begin
            p_step = t_trial - {1'b0, div_q};
            q_step = {q_q[N_W-2:0], 1'b1};
        end else begin
            p_step = t_trial;
            q_step = {q_q[N_W-2:0], 1'b0};
        end
    end

    assign last_iter = (cnt_q == CntW'(N_W - 1));

    // Next-state logic: accept in idle, iterate in run, publish results with done.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        p_d         = p_q;
        q_d         = q_q;
        div_d       = div_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (divisor_i == '0) begin
                        // Divide by zero completes immediately without entering run.
                        done_d      = 1'b1;
                        dbz_d       = 1'b1;
                        quotient_d  = '1;
                        remainder_d = dividend_i[D_W-1:0];
                    end else begin
                        state_d = StRun;
                        dbz_d   = 1'b0;
                        cnt_d   = '0;
                        p_d     = '0;
                        q_d     = dividend_i;
                        div_d   = divisor_i;
                    end
                end
            end
            StRun: begin
                p_d   = p_step;
                q_d   = q_step;
                cnt_d = cnt_q + CntW'(1);
                if (last_iter) begin
                    state_d     = StIdle;
                    done_d      = 1'b1;
                    quotient_d  = q_step;
                    remainder_d = p_step[D_W-1:0];
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            p_q         <= '0;
            q_q         <= '0;
            div_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            q_q         <= q_d;
            div_q       <= div_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy_o      = (state_q == StRun);
    assign done_o      = done_q;
    assign dbz_o       = dbz_q;
    assign quotient_o  = quotient_q;
    assign remainder_o = remainder_q;

endmodule

// File: tb/tb_div_16_by_8.sv
// Scoreboard bench for div_16_by_8: stimulus pushes expected results, a monitor pops them
// whenever done is seen and compares against the DUT outputs.
module tb_div_16_by_8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [15:0] dividend_i;
    logic [7:0]  divisor_i;
    logic        busy_o;
    logic        done_o;
    logic        dbz_o;
    logic [15:0] quotient_o;
    logic [7:0]  remainder_o;

    div_16_by_8 #(
        .N_W(16),
        .D_W(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .dbz_o      (dbz_o),
        .quotient_o (quotient_o),
        .remainder_o(remainder_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dbz;
        logic [15:0] dd;
        logic [7:0]  dv;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && done_o === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending operation");
            end else begin
                logic [31:0] hi, lo;
                mon_e = sb.pop_front();
                chk("quotient", 32'(quotient_o), 32'(mon_e.q));
                chk("remainder", 32'(remainder_o), 32'(mon_e.r));
                chk("dbz", 32'(dbz_o), 32'(mon_e.dbz));
                if (mon_e.dv != 8'd0) begin
                    // q*d built from two 8x8 partial products
                    hi = 32'(quotient_o[15:8]) * 32'(mon_e.dv);
                    lo = 32'(quotient_o[7:0]) * 32'(mon_e.dv);
                    chk("invariant", (hi << 8) + lo + 32'(remainder_o), 32'(mon_e.dd));
                    chk("rem_lt_div", 32'(remainder_o < mon_e.dv), 32'd1);
                end
            end
        end
    end

    // Drive a request at a negedge; it is accepted on the following posedge.
    task automatic issue(input logic [15:0] dd, input logic [7:0] dv, input bit expect_done);
        exp_t e;
        start_i    = 1'b1;
        dividend_i = dd;
        divisor_i  = dv;
        @(posedge clk);
        if (expect_done) begin
            e.dd  = dd;
            e.dv  = dv;
            e.dbz = (dv == 8'd0);
            e.q   = (dv == 8'd0) ? 16'hFFFF : dd / 16'(dv);
            e.r   = (dv == 8'd0) ? dd[7:0] : 8'(dd % 16'(dv));
            sb.push_back(e);
        end
        #1;
        start_i    = 1'b0;
        dividend_i = ~dd;          // post-accept changes must not matter
        divisor_i  = dv ^ 8'h5A;
    endtask

    // Count cycles after the accepting edge until done; optionally poke start while busy.
    task automatic wait_done(input int poke, output int lat, output int nbusy);
        lat   = 0;
        nbusy = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            lat = c;
            if (busy_o) nbusy++;
            if (c == poke) begin
                start_i    = 1'b1;
                dividend_i = 16'd9;
                divisor_i  = 8'd9;
            end
            if (c == poke + 1) start_i = 1'b0;
            if (done_o) break;
            if (c == 40) begin
                n_checks++;
                n_fail++;
                $display("FAIL done_timeout: got no done within 40 cycles expected done");
            end
        end
    endtask

    typedef struct {
        logic [15:0] dd;
        logic [7:0]  dv;
    } vec_t;

    initial begin
        int   lat, nb;
        vec_t vecs[5];
        vecs[0] = '{16'd5, 8'd9};
        vecs[1] = '{16'd0, 8'd1};
        vecs[2] = '{16'hFFFF, 8'd1};
        vecs[3] = '{16'h8000, 8'h80};
        vecs[4] = '{16'd12345, 8'd100};

        rst        = 1'b1;
        start_i    = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_dbz", 32'(dbz_o), 32'd0);
        chk("rst_quotient", 32'(quotient_o), 32'd0);
        chk("rst_remainder", 32'(remainder_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // T1: FFFF / FF, latency and one-cycle done pulse
        issue(16'hFFFF, 8'hFF, 1'b1);
        wait_done(0, lat, nb);
        chk("t1_latency", 32'(lat), 32'd17);
        chk("t1_busy_cycles", 32'(nb), 32'd16);
        @(negedge clk);
        chk("t1_done_pulse", 32'(done_o), 32'd0);
        chk("t1_quotient_held", 32'(quotient_o), 32'h0101);

        // T2: 1000 / 7
        issue(16'd1000, 8'd7, 1'b1);
        wait_done(0, lat, nb);
        chk("t2_latency", 32'(lat), 32'd17);
        chk("t2_busy_cycles", 32'(nb), 32'd16);

        // T3: boundary vectors, issued back-to-back in each done cycle
        foreach (vecs[i]) begin
            issue(vecs[i].dd, vecs[i].dv, 1'b1);
            wait_done(0, lat, nb);
            chk("t3_latency", 32'(lat), 32'd17);
        end

        // T4: divide by zero, then a valid op clears dbz
        issue(16'h1234, 8'd0, 1'b1);
        wait_done(0, lat, nb);
        chk("t4_latency", 32'(lat), 32'd1);
        chk("t4_busy_cycles", 32'(nb), 32'd0);
        @(negedge clk);
        chk("t4_dbz_held", 32'(dbz_o), 32'd1);
        chk("t4_quotient_held", 32'(quotient_o), 32'hFFFF);
        chk("t4_remainder_held", 32'(remainder_o), 32'h34);
        issue(16'd100, 8'd10, 1'b1);
        chk("t4_dbz_clear", 32'(dbz_o), 32'd0);
        wait_done(0, lat, nb);
        chk("t4b_latency", 32'(lat), 32'd17);

        // T5: back-to-back 200/3 with an ignored start while busy, then a DBZ in the done cycle
        issue(16'd200, 8'd3, 1'b1);
        wait_done(5, lat, nb);
        chk("t5_latency", 32'(lat), 32'd17);
        issue(16'h00AB, 8'd0, 1'b1);
        wait_done(0, lat, nb);
        chk("t5_dbz_latency", 32'(lat), 32'd1);
        @(negedge clk);
        chk("t5_done_pulse", 32'(done_o), 32'd0);

        // T6: reset mid-run abandons the op; then 255/16 completes normally
        issue(16'd1000, 8'd7, 1'b0);
        repeat (7) @(negedge clk);
        chk("t6_busy_before_rst", 32'(busy_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", 32'(busy_o), 32'd0);
        chk("t6_rst_done", 32'(done_o), 32'd0);
        chk("t6_rst_dbz", 32'(dbz_o), 32'd0);
        chk("t6_rst_quotient", 32'(quotient_o), 32'd0);
        chk("t6_rst_remainder", 32'(remainder_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        issue(16'd255, 8'd16, 1'b1);
        wait_done(0, lat, nb);
        chk("t6_latency", 32'(lat), 32'd17);

        // Random pairs checked by the monitor against the model and the invariant
        for (int i = 0; i < 64; i++) begin
            issue(16'($urandom), 8'($urandom_range(1, 255)), 1'b1);
            wait_done(0, lat, nb);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
